// File: rtl/output_glitch_filter.sv
// Synchronises the hazard-prone output of a gate network and accepts a new
// level only once it has held for STABLE_CYCLES cycles; counts edges and glitches.
module output_glitch_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             o_in,
  input  logic             clr,
  output logic             o_filt,
  output logic             o_rise,
  output logic             o_fall,
  output logic             busy,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int unsigned     RUN_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
  localparam bit               IMMEDIATE = (STABLE_CYCLES == 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  logic             q1_q, s_q;
  state_e           state_q;
  logic [RUN_W-1:0] run_cnt_q;
  logic             o_filt_q, rise_q, fall_q, busy_q;
  logic [CNT_W-1:0] rise_cnt_q, fall_cnt_q, glitch_cnt_q;
  logic [CNT_W-1:0] rise_cnt_d, fall_cnt_d, glitch_cnt_d;

  logic differ, qualified, glitch, accept_rise, accept_fall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Two-flop synchroniser; only s_q is allowed to feed the rest of the design.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; a blocking q1 would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      q1_q <= o_in;
      s_q  <= q1_q;
    end
  end

  // Decode this cycle's outcome; a reversal in PEND wins over the final count.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    differ    = s_q ^ o_filt_q;
    qualified = 1'b0;
    glitch    = 1'b0;
    if (state_q == ST_IDLE) begin
      qualified = differ && IMMEDIATE;
    end else begin
      glitch    = !differ;
      qualified = differ && (run_cnt_q == RUN_LAST);
    end
    accept_rise = qualified && s_q;
    accept_fall = qualified && !s_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      run_cnt_q <= '0;
      o_filt_q  <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rise_q <= accept_rise;
      fall_q <= accept_fall;
      if (qualified) begin
        o_filt_q <= s_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (differ && !IMMEDIATE) begin
            state_q   <= ST_PEND;
            run_cnt_q <= RUN_W'(1);
            busy_q    <= 1'b1;
          end
        end
        ST_PEND: begin
          if (glitch || qualified) begin
            state_q   <= ST_IDLE;
            run_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            run_cnt_q <= run_cnt_q + RUN_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          run_cnt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Counters saturate; clr overrides any increment landing on the same edge.
  always_comb begin
    rise_cnt_d   = rise_cnt_q;
    fall_cnt_d   = fall_cnt_q;
    glitch_cnt_d = glitch_cnt_q;
    if (clr) begin
      rise_cnt_d   = '0;
      fall_cnt_d   = '0;
      glitch_cnt_d = '0;
    end else begin
      if (accept_rise) rise_cnt_d   = sat_inc(rise_cnt_q);
      if (accept_fall) fall_cnt_d   = sat_inc(fall_cnt_q);
      if (glitch)      glitch_cnt_d = sat_inc(glitch_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_cnt_q   <= '0;
      fall_cnt_q   <= '0;
      glitch_cnt_q <= '0;
    end else begin
      rise_cnt_q   <= rise_cnt_d;
      fall_cnt_q   <= fall_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign o_filt     = o_filt_q;
  assign o_rise     = rise_q;
  assign o_fall     = fall_q;
  assign busy       = busy_q;
  assign rise_cnt   = rise_cnt_q;
  assign fall_cnt   = fall_cnt_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule
